// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a busy-bit scoreboard for in-order issue.
// Reads are combinational; writes, reserves and flushes take effect at the rising edge.
module regfile_scoreboard #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    input  logic                 flush,
    output logic [NREGS-1:0]     busy_vec
);

    localparam logic [AW:0] NR = NREGS[AW:0];

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_wr_ok;
    logic             w_rsv_ok;

    // Address names a real, writable register (excludes hardwired x0 and holes past NREGS).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NR) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Gating with reset keeps a write presented in the reset cycle from bypassing to reads.
    assign w_wr_ok  = wr_en  && !reset && addr_ok(wr_addr);
    assign w_rsv_ok = rsv_en && !reset && addr_ok(rsv_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Priority: flush, then write-clear, then reserve-set (reserve wins on collision).
    always_comb begin
        w_busy_nxt = flush ? '0 : r_busy;
        if (w_wr_ok)  w_busy_nxt[wr_addr]  = 1'b0;
        if (w_rsv_ok) w_busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) r_busy <= '0;
        else       r_busy <= w_busy_nxt;
    end

    assign busy_vec = r_busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_a;
        logic          w_ok;
        logic          w_hit;

        assign w_a   = rd_addr[k*AW +: AW];
        assign w_ok  = addr_ok(w_a);
        assign w_hit = (BYPASS != 0) && w_wr_ok && (wr_addr == w_a);

        assign rd_data[k*XLEN +: XLEN] = !w_ok ? '0 : (w_hit ? wr_data : r_regs[w_a]);
        assign rd_busy[k]              = w_ok && !w_hit && r_busy[w_a];
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers (2..256); AW = clog2(NREGS) is a localparam.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, where 1 hardwires register 0 to zero.
REQ-005 SHALL have parameter BYPASS, default 1, where 1 forwards same-cycle write data to reads.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port rd_addr, input, NRD*AW bits: read addresses, port k at bits [k*AW +: AW].
REQ-009 SHALL have port rd_data, output, NRD*XLEN bits: read data, port k at bits [k*XLEN +: XLEN].
REQ-010 SHALL have port rd_busy, output, NRD bits: pending-write flag for each read address.
REQ-011 SHALL have port wr_en, input, 1 bit: write strobe.
REQ-012 SHALL have port wr_addr, input, AW bits: write address.
REQ-013 SHALL have port wr_data, input, XLEN bits: write data.
REQ-014 SHALL have port rsv_en, input, 1 bit: reserve strobe, marking a destination busy at issue.
REQ-015 SHALL have port rsv_addr, input, AW bits: address to reserve.
REQ-016 SHALL have port flush, input, 1 bit: clears all busy bits (pipeline squash).
REQ-017 SHALL have port busy_vec, output, NREGS bits: registered scoreboard, bit i = register i busy.

Function
REQ-018 Reads SHALL be combinational from rd_addr, with zero cycles of latency.
REQ-019 A write with wr_en=1 SHALL update the register at the rising edge, and the stored value SHALL be visible on reads in the following cycle.
REQ-020 With BYPASS=1, a read whose address matches an active write in the same cycle SHALL return wr_data; with BYPASS=0 it SHALL return the old stored value.
REQ-021 With ZERO_REG=1, reads of address 0 SHALL return 0, rd_busy for address 0 SHALL be 0, and writes and reserves to address 0 SHALL be ignored (no bypass of address 0).
REQ-022 For an address >= NREGS, reads SHALL return 0 with rd_busy=0, and writes and reserves SHALL be ignored.
REQ-023 The busy bit update per edge SHALL be applied in this order:
- flush=1 clears all bits;
- then a write clears bit[wr_addr];
- then a reserve sets bit[rsv_addr].
REQ-024 When rsv_addr equals wr_addr in the same cycle, the reserve SHALL win: the busy bit is 1 and the data is still written.
REQ-025 Writes SHALL commit during flush, and a reserve in the same cycle as flush SHALL leave exactly bit[rsv_addr] set.
REQ-026 rd_busy[k] SHALL equal busy_vec[rd_addr_k] masked by a same-cycle write to that address (0 if written this cycle, when BYPASS=1), and a same-cycle reserve SHALL NOT be reflected until the next cycle.
REQ-027 A write to a non-busy register SHALL be legal and SHALL leave the busy bit at 0.
REQ-028 Multiple read ports addressing the same register SHALL return identical data and busy values.

Reset
REQ-029 On reset=1 at the rising edge, all registers SHALL be set to 0 and busy_vec SHALL be set to all zeros, regardless of wr_en, rsv_en or flush.
REQ-030 During reset, rd_data SHALL reflect stored contents per REQ-018..022, so it reads 0 one cycle after reset is sampled.
REQ-031 Reset asserted mid-operation SHALL discard all pending reservations and data within one edge, and no write presented in the reset cycle SHALL be retained.

Verification
REQ-032 Reset, then write x5=0xDEADBEEF, then the next cycle read x5 on port0 and x0 on port1: the bench SHALL check rd_data port0=0xDEADBEEF and port1=0.
REQ-033 Write x7=0x12345678 with rd_addr0=7 in the same cycle: the bench SHALL check rd_data0=0x12345678 when BYPASS=1 and the old value 0 when BYPASS=0.
REQ-034 Reserve x3, then the next cycle read x3: the bench SHALL check rd_busy=1 and busy_vec[3]=1; after writing x3=0xA5, the next cycle SHALL show rd_busy=0 and data=0xA5.
REQ-035 In the same cycle, reserve x4 and write x4=0x55: the bench SHALL check that the next cycle shows busy_vec[4]=1 and data=0x55.
REQ-036 Reserve x1, x2 and x9, then flush with rsv_addr=9: the bench SHALL check busy_vec = only bit 9 set; writing x0=0xFF SHALL leave x0 reading 0.
REQ-037 Fill all registers with their index values, assert reset for one cycle with wr_en=1 to x10: the bench SHALL check that all registers read 0 and busy_vec=0.
